// File: rtl/seq_divider.sv
// Multi-cycle non-restoring integer divider with RISC-V M semantics (div, divu, rem, remu).
// One quotient bit per cycle; divide-by-zero and signed overflow finish immediately.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             ready,
    output logic             resp,
    output logic [WIDTH-1:0] f
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             a_neg_q, a_neg_d;
    logic             b_neg_q, b_neg_d;
    logic             div_zero_q, div_zero_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] f_q, f_d;

    logic             signed_in;
    logic             a_neg_in;
    logic             b_neg_in;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             zero_in;
    logic             ovf_in;

    assign signed_in = ~op[0];
    assign a_neg_in  = signed_in & a[WIDTH-1];
    assign b_neg_in  = signed_in & b[WIDTH-1];
    assign a_mag     = a_neg_in ? (~a + ONE) : a;
    assign b_mag     = b_neg_in ? (~b + ONE) : b;
    assign zero_in   = (b == '0);
    assign ovf_in    = signed_in && (a == MIN_INT) && (b == '1);

    // One non-restoring step: the remainder stays WIDTH+1 bits wide and the
    // modular wrap of the dropped top bit is harmless because every result lies in [-dvs, dvs).
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   dvs_ext;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] rem_fix;
    logic             q_neg;
    logic             r_neg;
    logic [WIDTH-1:0] quo_res;
    logic [WIDTH-1:0] rem_res;
    logic [WIDTH-1:0] result;
    logic             last_iter;

    assign shifted   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign dvs_ext   = {1'b0, dvs_q};
    assign rem_step  = rem_q[WIDTH] ? (shifted + dvs_ext) : (shifted - dvs_ext);
    assign quo_step  = {quo_q[WIDTH-2:0], ~rem_step[WIDTH]};
    assign rem_fix   = rem_step[WIDTH] ? (rem_step[WIDTH-1:0] + dvs_q) : rem_step[WIDTH-1:0];
    assign q_neg     = ~op_q[0] & (a_neg_q ^ b_neg_q);
    assign r_neg     = ~op_q[0] & a_neg_q;
    assign quo_res   = q_neg ? (~quo_step + ONE) : quo_step;
    assign rem_res   = r_neg ? (~rem_fix + ONE) : rem_fix;
    assign result    = op_q[1] ? rem_res : quo_res;
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    assign ready = (state_q == IDLE);
    assign resp  = (state_q == DONE) && !flush;
    assign f     = f_q;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_neg_d    = a_neg_q;
        b_neg_d    = b_neg_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        cnt_d      = cnt_q;
        f_d        = f_q;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d       = op;
                    a_neg_d    = a_neg_in;
                    b_neg_d    = b_neg_in;
                    div_zero_d = zero_in;
                    ovf_d      = ovf_in;
                    rem_d      = '0;
                    quo_d      = a_mag;
                    dvs_d      = b_mag;
                    cnt_d      = '0;
                    if (zero_in) begin
                        f_d     = op[1] ? a : '1;
                        state_d = DONE;
                    end else if (ovf_in) begin
                        f_d     = op[1] ? '0 : MIN_INT;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (div_zero_q || ovf_q) begin
                    // Special cases never iterate; their result was already produced at accept.
                    state_d = DONE;
                end else begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        f_d     = result;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            f_q        <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_neg_q    <= a_neg_d;
            b_neg_q    <= b_neg_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            cnt_q      <= cnt_d;
            f_q        <= f_d;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: a 32-bit and an 8-bit instance checked against
// an arithmetic RISC-V M reference model with directed and randomized operations.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst;

    logic        start32, flush32, ready32, resp32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, f32;

    logic        start8, flush8, ready8, resp8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, f8;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    seq_divider #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .op(op32), .a(a32), .b(b32),
        .flush(flush32), .ready(ready32), .resp(resp32), .f(f32)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .flush(flush8), .ready(ready8), .resp(resp8), .f(f8)
    );

    always #5 clk = ~clk;

    function automatic longint sext(input int w, input logic [63:0] x);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return x[w-1] ? longint'(x | ~mask) : longint'(x & mask);
    endfunction

    // RISC-V M results from plain arithmetic (division truncates toward zero).
    function automatic logic [63:0] ref_result(input int w, input logic [1:0] o,
                                               input logic [63:0] x, input logic [63:0] y);
        logic [63:0] mask;
        longint ux, uy, sx, sy, r;
        mask = (64'd1 << w) - 64'd1;
        ux = longint'(x & mask);
        uy = longint'(y & mask);
        sx = sext(w, x);
        sy = sext(w, y);
        if (uy == 0)    r = o[1] ? ux : longint'(mask);
        else if (!o[0]) r = o[1] ? (sx % sy) : (sx / sy);
        else            r = o[1] ? (ux % uy) : (ux / uy);
        return 64'(r) & mask;
    endfunction

    function automatic int ref_latency(input int w, input logic [1:0] o,
                                       input logic [63:0] x, input logic [63:0] y);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        if ((y & mask) == 64'd0) return 1;
        if (!o[0] && sext(w, y) == -1 && sext(w, x) == -(longint'(1) << (w - 1))) return 1;
        return w + 1;
    endfunction

    task automatic do_op32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] fo, output int resp_at, output int ready_at,
                           output int pulses);
        op32 = o; a32 = x; b32 = y; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        a32 = $urandom; b32 = $urandom; op32 = 2'($urandom);
        fo = f32; resp_at = -1; ready_at = -1; pulses = 0;
        for (int k = 1; k <= 60; k++) begin
            if (resp32) begin
                pulses++;
                if (resp_at < 0) begin resp_at = k; fo = f32; end
            end
            if (ready32) begin ready_at = k; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic do_op8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                          output logic [7:0] fo, output int resp_at, output int ready_at);
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        fo = f8; resp_at = -1; ready_at = -1;
        for (int k = 1; k <= 30; k++) begin
            if (resp8 && resp_at < 0) begin resp_at = k; fo = f8; end
            if (ready8) begin ready_at = k; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (ready32 !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready32: got %b want 1", ready32); end
        total++; if (resp32 !== 1'b0) begin bad++; $display("[TB] FAIL reset_resp32: got %b want 0", resp32); end
        total++; if (f32 !== 32'h0) begin bad++; $display("[TB] FAIL reset_f32: got %h want 0", f32); end
        total++; if (ready8 !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready8: got %b want 1", ready8); end
        total++; if (f8 !== 8'h0) begin bad++; $display("[TB] FAIL reset_f8: got %h want 0", f8); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [1:0]  ops[9] = '{OP_DIV, OP_REM, OP_DIV, OP_REM, OP_REMU, OP_DIVU, OP_REM, OP_DIV, OP_REM};
        logic [31:0] as[9]  = '{32'd100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                32'd5, 32'hFFFFFFFB, 32'h80000000, 32'h80000000};
        logic [31:0] bs[9]  = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0,
                                32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] fs[9]  = '{32'd14, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd1,
                                32'hFFFFFFFF, 32'hFFFFFFFB, 32'h80000000, 32'd0};
        int          lat[9] = '{33, 33, 33, 33, 33, 1, 1, 1, 1};
        logic [31:0] fo;
        int          resp_at, ready_at, pulses;
        for (int i = 0; i < 9; i++) begin
            do_op32(ops[i], as[i], bs[i], fo, resp_at, ready_at, pulses);
            total++; if (fo !== fs[i]) begin bad++; $display("[TB] FAIL directed_f[%0d]: got %h want %h", i, fo, fs[i]); end
            total++; if (resp_at != lat[i]) begin bad++; $display("[TB] FAIL directed_resp_at[%0d]: got %0d want %0d", i, resp_at, lat[i]); end
            total++; if (ready_at != lat[i] + 1) begin bad++; $display("[TB] FAIL directed_ready_at[%0d]: got %0d want %0d", i, ready_at, lat[i] + 1); end
            total++; if (pulses != 1) begin bad++; $display("[TB] FAIL directed_pulses[%0d]: got %0d want 1", i, pulses); end
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] x, y, fo, fexp;
        int          resp_at, ready_at, pulses, lexp, sel;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom); x = $urandom; y = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) y = 32'd0;
            else if (sel == 1) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
            else if (sel == 2) y = 32'($urandom_range(1, 20));
            else if (sel == 3) y = -32'($urandom_range(1, 20));
            fexp = ref_result(32, o, 64'(x), 64'(y))[31:0];
            lexp = ref_latency(32, o, 64'(x), 64'(y));
            do_op32(o, x, y, fo, resp_at, ready_at, pulses);
            total++; if (fo !== fexp) begin bad++; $display("[TB] FAIL random_f op=%0d a=%h b=%h: got %h want %h", o, x, y, fo, fexp); end
            total++; if (resp_at != lexp) begin bad++; $display("[TB] FAIL random_resp_at op=%0d a=%h b=%h: got %0d want %0d", o, x, y, resp_at, lexp); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] fo;
        int          resp_at, ready_at, pulses, seen;
        do_op32(OP_DIV, 32'd100, 32'd7, fo, resp_at, ready_at, pulses);

        op32 = OP_DIV; a32 = 32'd1000; b32 = 32'd3; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        seen = 0;
        for (int k = 1; k < 10; k++) begin
            if (resp32) seen++;
            @(posedge clk); #1;
        end
        flush32 = 1'b1;
        @(posedge clk); #1;
        flush32 = 1'b0;
        total++; if (ready32 !== 1'b1) begin bad++; $display("[TB] FAIL flush_calc_idle: got %b want 1", ready32); end
        for (int k = 0; k < 40; k++) begin
            if (resp32) seen++;
            @(posedge clk); #1;
        end
        total++; if (seen != 0) begin bad++; $display("[TB] FAIL flush_calc_resp: got %0d pulses want 0", seen); end
        total++; if (f32 !== 32'd14) begin bad++; $display("[TB] FAIL flush_calc_f: got %h want %h", f32, 32'd14); end

        op32 = OP_DIV; a32 = 32'd9; b32 = 32'd3; start32 = 1'b1; flush32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0; flush32 = 1'b0;
        total++; if (ready32 !== 1'b1) begin bad++; $display("[TB] FAIL flush_start_ready: got %b want 1", ready32); end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (resp32) seen++;
            @(posedge clk); #1;
        end
        total++; if (seen != 0) begin bad++; $display("[TB] FAIL flush_start_resp: got %0d pulses want 0", seen); end
        total++; if (f32 !== 32'd14) begin bad++; $display("[TB] FAIL flush_start_f: got %h want %h", f32, 32'd14); end

        op32 = OP_DIVU; a32 = 32'd5; b32 = 32'd0; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        total++; if (resp32 !== 1'b1) begin bad++; $display("[TB] FAIL done_resp: got %b want 1", resp32); end
        flush32 = 1'b1;
        #1;
        total++; if (resp32 !== 1'b0) begin bad++; $display("[TB] FAIL done_flush_mask: got %b want 0", resp32); end
        @(posedge clk); #1;
        flush32 = 1'b0;
        total++; if (ready32 !== 1'b1) begin bad++; $display("[TB] FAIL done_flush_idle: got %b want 1", ready32); end
    endtask

    task automatic test_reset_mid();
        int seen;
        op32 = OP_DIV; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        seen = 0;
        for (int k = 1; k < 5; k++) begin
            if (resp32) seen++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (ready32 !== 1'b1) begin bad++; $display("[TB] FAIL midreset_ready: got %b want 1", ready32); end
        total++; if (f32 !== 32'd0) begin bad++; $display("[TB] FAIL midreset_f: got %h want 0", f32); end
        for (int k = 0; k < 40; k++) begin
            if (resp32) seen++;
            @(posedge clk); #1;
        end
        total++; if (seen != 0) begin bad++; $display("[TB] FAIL midreset_resp: got %0d pulses want 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  bo[4];
        logic [31:0] ba[4], bb[4];
        logic [31:0] expq[$];
        logic [31:0] e;
        logic        prev_ready;
        int          idx, got, wasted;
        for (int i = 0; i < 4; i++) begin
            bo[i] = 2'($urandom); ba[i] = $urandom; bb[i] = 32'($urandom_range(1, 1000));
        end
        bb[2] = 32'd0;
        idx = 0; got = 0; wasted = 0;
        op32 = bo[0]; a32 = ba[0]; b32 = bb[0]; start32 = 1'b1;
        prev_ready = ready32;
        for (int c = 0; c < 300 && got < 4; c++) begin
            @(posedge clk); #1;
            if (prev_ready && start32) begin
                expq.push_back(ref_result(32, bo[idx], 64'(ba[idx]), 64'(bb[idx]))[31:0]);
                idx++;
                if (idx < 4) begin op32 = bo[idx]; a32 = ba[idx]; b32 = bb[idx]; end
                else start32 = 1'b0;
                if (ready32) wasted++;
            end
            if (resp32) begin
                e = (expq.size() > 0) ? expq.pop_front() : 32'hDEADBEEF;
                total++; if (f32 !== e) begin bad++; $display("[TB] FAIL b2b_f[%0d]: got %h want %h", got, f32, e); end
                got++;
            end
            prev_ready = ready32;
        end
        start32 = 1'b0;
        total++; if (got != 4) begin bad++; $display("[TB] FAIL b2b_count: got %0d want 4", got); end
        total++; if (wasted != 0) begin bad++; $display("[TB] FAIL b2b_idle_gap: got %0d extra idle cycles want 0", wasted); end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_width8();
        logic [7:0] avals[20] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd17, 8'd34, 8'd51, 8'd100, 8'd126,
                                  8'd127, 8'd128, 8'd129, 8'd150, 8'd200, 8'd221, 8'd249, 8'd253, 8'd254, 8'd255};
        logic [7:0] bvals[10] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd127, 8'd128, 8'd200, 8'd254, 8'd255};
        logic [7:0] fo, fexp;
        logic [1:0] o;
        int         resp_at, ready_at, lexp;
        do_op8(OP_DIVU, 8'd200, 8'd3, fo, resp_at, ready_at);
        total++; if (fo !== 8'd66) begin bad++; $display("[TB] FAIL w8_divu_f: got %0d want 66", fo); end
        total++; if (resp_at != 9) begin bad++; $display("[TB] FAIL w8_divu_resp_at: got %0d want 9", resp_at); end
        for (int oi = 0; oi < 4; oi++) begin
            o = 2'(oi);
            for (int i = 0; i < 20; i++) begin
                for (int j = 0; j < 11; j++) begin
                    logic [7:0] y;
                    y = (j < 10) ? bvals[j] : 8'($urandom);
                    fexp = ref_result(8, o, 64'(avals[i]), 64'(y))[7:0];
                    lexp = ref_latency(8, o, 64'(avals[i]), 64'(y));
                    do_op8(o, avals[i], y, fo, resp_at, ready_at);
                    total++; if (fo !== fexp) begin bad++; $display("[TB] FAIL w8_sweep_f op=%0d a=%h b=%h: got %h want %h", o, avals[i], y, fo, fexp); end
                    total++; if (resp_at != lexp) begin bad++; $display("[TB] FAIL w8_sweep_resp_at op=%0d a=%h b=%h: got %0d want %0d", o, avals[i], y, resp_at, lexp); end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start32 = 1'b0; flush32 = 1'b0; op32 = 2'b00; a32 = '0; b32 = '0;
        start8 = 1'b0; flush8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_width8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
